// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP32 adder scheduler.
package fp_sched_pkg;

  localparam int unsigned NUM_STAGES = 5;

  localparam int unsigned STG_MASK  = 0;
  localparam int unsigned STG_ALIGN = 1;
  localparam int unsigned STG_ALU   = 2;
  localparam int unsigned STG_NORM  = 3;
  localparam int unsigned STG_PACK  = 4;

  typedef enum logic [2:0] {
    IDLE,
    MASK,
    ALIGN,
    ALU,
    NORM,
    PACK,
    RESP
  } schedStateT;

  // IDLE and RESP map to no active stage.
  function automatic logic [NUM_STAGES-1:0] stageEnable(input schedStateT st);
    logic [NUM_STAGES-1:0] en;
    en = '0;
    case (st)
      MASK:    en[STG_MASK]  = 1'b1;
      ALIGN:   en[STG_ALIGN] = 1'b1;
      ALU:     en[STG_ALU]   = 1'b1;
      NORM:    en[STG_NORM]  = 1'b1;
      PACK:    en[STG_PACK]  = 1'b1;
      default: en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the caller updates its last-grant pointer when grantValid is used.
module rr_arbiter2 (
  input  logic [1:0] reqValid,
  input  logic       lastGrant,
  output logic       grantValid,
  output logic       grantId
);

  always_comb begin
    grantValid = |reqValid;
    grantId    = 1'b0;
    if (&reqValid) begin
      grantId = ~lastGrant;
    end else begin
      grantId = reqValid[1];
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one five-stage FP32 adder datapath between two requesters, round-robin,
// returning each sum on a valid/ready response channel tagged with the requester id.
module fp_add_scheduler #(
  parameter int unsigned CNT_W   = 16,
  parameter logic        RR_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic [4:0]       dp_stage_en,
  input  logic [31:0]      dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  import fp_sched_pkg::*;

  schedStateT stateQ, stateD;
  logic       lastGrantQ;
  logic       grantValid;
  logic       grantId;
  logic       accept;

  rr_arbiter2 uArb (
    .reqValid  ({req1_valid, req0_valid}),
    .lastGrant (lastGrantQ),
    .grantValid(grantValid),
    .grantId   (grantId)
  );

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (grantValid) begin
          accept = 1'b1;
          stateD = MASK;
        end
      end
      MASK:  stateD = ALIGN;
      ALIGN: stateD = ALU;
      ALU:   stateD = NORM;
      NORM:  stateD = PACK;
      PACK:  stateD = RESP;
      RESP: begin
        if (rsp_ready) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  assign req0_ready  = accept & ~grantId;
  assign req1_ready  = accept & grantId;
  assign busy        = (stateQ != IDLE);
  assign dp_stage_en = stageEnable(stateQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= IDLE;
      lastGrantQ <= RR_INIT;
      dp_a       <= '0;
      dp_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      ops_done   <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        dp_a       <= grantId ? req1_a : req0_a;
        dp_b       <= grantId ? req1_b : req0_b;
        rsp_id     <= grantId;
        lastGrantQ <= grantId;
      end
      // The datapath result is only meaningful while the pack stage is enabled.
      if (stateQ == PACK) begin
        rsp_result <= dp_result;
        rsp_valid  <= 1'b1;
      end
      if ((stateQ == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (ops_done != {CNT_W{1'b1}}) ops_done <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench: operation-level reference model checked every cycle, a vector table,
// and directed sequences for contention, backpressure, mid-op reset, saturation and isolation.
module tb_fp_add_scheduler;

  localparam logic RR_INIT = 1'b1;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        expId;
    logic [31:0] expRes;
  } vecT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, v0, v1, rspReady;
  logic [31:0] a0, b0, a1, b1;

  logic        dReq0Ready, dReq1Ready, dRspValid, dRspId, dBusy;
  logic [31:0] dDpA, dDpB, dDpResult, dRspResult;
  logic [4:0]  dStageEn;
  logic [15:0] dOps;

  logic        sReq0Ready, sReq1Ready, sRspValid, sRspId, sBusy;
  logic [31:0] sDpA, sDpB, sDpResult, sRspResult;
  logic [4:0]  sStageEn;
  logic [2:0]  sOps;

  int nChecks = 0;
  int nFail   = 0;

  // Reference operation model.
  int          mPhase;
  logic        mLast, mId;
  logic [31:0] mA, mB, mRes;
  int          mDone;
  bit          checkEn;
  int          grantQ[$];

  // Behavioural adder for non-negative values that are multiples of 1/256 below 512.
  function automatic logic [63:0] fpToFix(input logic [31:0] f);
    int          e;
    logic [63:0] m;
    e = int'(f[30:23]);
    m = {40'd0, 1'b1, f[22:0]};
    if (e == 0) return 64'd0;
    if (e >= 142) return m << (e - 142);
    return m >> (142 - e);
  endfunction

  function automatic logic [31:0] fixToFp(input logic [63:0] v);
    int          p;
    logic [63:0] m;
    logic [7:0]  e;
    if (v == 64'd0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    m = (p >= 23) ? (v >> (p - 23)) : (v << (23 - p));
    e = 8'(p + 119);
    return {1'b0, e, m[22:0]};
  endfunction

  function automatic logic [31:0] fpAddModel(input logic [31:0] x, input logic [31:0] y);
    return fixToFp(fpToFix(x) + fpToFix(y));
  endfunction

  function automatic logic [31:0] randFp();
    return fixToFp(64'($urandom_range(1, 65535)));
  endfunction

  assign dDpResult = dStageEn[4] ? fpAddModel(dDpA, dDpB) : 32'hDEAD_BEEF;
  assign sDpResult = sStageEn[4] ? fpAddModel(sDpA, sDpB) : 32'hDEAD_BEEF;

  fp_add_scheduler #(.CNT_W(16), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(dReq0Ready),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(dReq1Ready),
    .dp_a(dDpA), .dp_b(dDpB), .dp_stage_en(dStageEn), .dp_result(dDpResult),
    .rsp_valid(dRspValid), .rsp_ready(rspReady), .rsp_result(dRspResult), .rsp_id(dRspId),
    .busy(dBusy), .ops_done(dOps)
  );

  fp_add_scheduler #(.CNT_W(3), .RR_INIT(RR_INIT)) dutSat (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(sReq0Ready),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(sReq1Ready),
    .dp_a(sDpA), .dp_b(sDpB), .dp_stage_en(sStageEn), .dp_result(sDpResult),
    .rsp_valid(sRspValid), .rsp_ready(rspReady), .rsp_result(sRspResult), .rsp_id(sRspId),
    .busy(sBusy), .ops_done(sOps)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    logic g0, g1;
    #1;
    g0 = (mPhase == 0) && v0 && (!v1 || mLast);
    g1 = (mPhase == 0) && v1 && (!v0 || !mLast);
    if (checkEn) begin
      chk("req0_ready", 32'(dReq0Ready), 32'(g0));
      chk("req1_ready", 32'(dReq1Ready), 32'(g1));
      chk("stage_en", 32'(dStageEn), (mPhase >= 1 && mPhase <= 5) ? (32'd1 << (mPhase - 1)) : 0);
      chk("rsp_valid", 32'(dRspValid), 32'(mPhase == 6));
      chk("busy", 32'(dBusy), 32'(mPhase != 0));
      chk("dp_a", dDpA, mA);
      chk("dp_b", dDpB, mB);
      chk("rsp_result", dRspResult, mRes);
      chk("rsp_id", 32'(dRspId), 32'(mId));
      chk("ops_done", 32'(dOps), 32'(mDone));
      chk("ops_done_sat", 32'(sOps), (mDone > 7) ? 32'd7 : 32'(mDone));
    end
    if (dReq0Ready === 1'b1) grantQ.push_back(0);
    if (dReq1Ready === 1'b1) grantQ.push_back(1);
    @(posedge clk);
    if (reset) begin
      mPhase = 0; mLast = RR_INIT; mId = 1'b0;
      mA = '0; mB = '0; mRes = '0; mDone = 0;
    end else if (mPhase == 0) begin
      if (g0 || g1) begin
        mId = g1; mLast = g1;
        mA = g1 ? a1 : a0;
        mB = g1 ? b1 : b0;
        mPhase = 1;
      end
    end else if (mPhase < 5) begin
      mPhase++;
    end else if (mPhase == 5) begin
      mRes = fpAddModel(mA, mB);
      mPhase = 6;
    end else if (rspReady) begin
      mPhase = 0;
      mDone++;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    v0 = 1'b0; v1 = 1'b0; rspReady = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic runOp(input vecT t, input string tag);
    int k;
    v0 = t.v0; v1 = t.v1; a0 = t.a0; b0 = t.b0; a1 = t.a1; b1 = t.b1; rspReady = 1'b1;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    k = 0;
    while (dRspValid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd5);
    chk({tag, "_result"}, dRspResult, t.expRes);
    chk({tag, "_id"}, 32'(dRspId), 32'(t.expId));
    tick();
  endtask

  vecT tbl[5];

  initial begin
    vecT op;
    int  k;
    tbl[0] = '{1, 0, 32'h3FC0_0000, 32'h4020_0000, 32'h0, 32'h0, 0, 32'h4080_0000};
    tbl[1] = '{0, 1, 32'h0, 32'h0, 32'h3F80_0000, 32'h4000_0000, 1, 32'h4040_0000};
    tbl[2] = '{1, 1, 32'h4040_0000, 32'h3F80_0000, 32'h4120_0000, 32'h40A0_0000, 0, 32'h4080_0000};
    tbl[3] = '{1, 1, 32'h4040_0000, 32'h3F80_0000, 32'h4120_0000, 32'h40A0_0000, 1, 32'h4170_0000};
    tbl[4] = '{1, 1, 32'h3F00_0000, 32'h3E80_0000, 32'h4120_0000, 32'h40A0_0000, 0, 32'h3F40_0000};

    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    checkEn = 1'b0;
    @(negedge clk);
    doReset();
    checkEn = 1'b1;

    // Reset state.
    #1;
    chk("rst_busy", 32'(dBusy), 32'd0);
    chk("rst_stage", 32'(dStageEn), 32'd0);
    chk("rst_rsp_valid", 32'(dRspValid), 32'd0);
    chk("rst_ops", 32'(dOps), 32'd0);
    chk("rst_dp_a", dDpA, 32'd0);

    // Vector table; first entry is the single-request case.
    for (int i = 0; i < 5; i++) begin
      runOp(tbl[i], "tbl");
      chk("tbl_ops", 32'(dOps), 32'(i + 1));
    end

    // Contention: both requesters valid from reset, grants alternate.
    doReset();
    grantQ.delete();
    v0 = 1'b1; a0 = 32'h3FC0_0000; b0 = 32'h4020_0000;
    v1 = 1'b1; a1 = 32'h3F80_0000; b1 = 32'h4000_0000;
    for (int i = 0; i < 42; i++) tick();
    chk("cont_grants", 32'(grantQ.size()), 32'd6);
    for (int i = 0; i < grantQ.size(); i++) chk("cont_alt", 32'(grantQ[i]), 32'(i % 2));

    // Response backpressure.
    doReset();
    v0 = 1'b1; a0 = 32'h3FC0_0000; b0 = 32'h4020_0000; rspReady = 1'b0;
    tick();
    v0 = 1'b0;
    k = 0;
    while (dRspValid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("bp_latency", 32'(k), 32'd5);
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_result", dRspResult, 32'h4080_0000);
      chk("bp_id", 32'(dRspId), 32'd0);
      chk("bp_busy", 32'(dBusy), 32'd1);
      chk("bp_ready", {30'd0, dReq1Ready, dReq0Ready}, 32'd0);
      tick();
    end
    rspReady = 1'b1;
    #1;
    chk("bp_no_accept_in_resp", {30'd0, dReq1Ready, dReq0Ready}, 32'd0);
    tick();
    #1;
    chk("bp_next_accept", {30'd0, dReq1Ready, dReq0Ready}, 32'd2);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();

    // Reset during the ALU stage.
    doReset();
    v0 = 1'b1; a0 = 32'h4120_0000; b0 = 32'h40A0_0000;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_in_alu", 32'(dStageEn), 32'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_stage", 32'(dStageEn), 32'd0);
    chk("mid_rsp_valid", 32'(dRspValid), 32'd0);
    chk("mid_busy", 32'(dBusy), 32'd0);
    chk("mid_ops", 32'(dOps), 32'd0);
    runOp(tbl[0], "mid_after");

    // Saturation of the narrow counter.
    doReset();
    for (int i = 1; i <= 9; i++) begin
      op = '{1, 0, randFp(), randFp(), 32'h0, 32'h0, 0, 32'h0};
      op.expRes = fpAddModel(op.a0, op.b0);
      runOp(op, "sat");
      if (i == 7) chk("sat_at7", 32'(sOps), 32'd7);
    end
    chk("sat_final", 32'(sOps), 32'd7);
    chk("sat_wide", 32'(dOps), 32'd9);

    // Operand isolation: requester inputs churn after acceptance.
    doReset();
    v0 = 1'b1; a0 = 32'h4040_0000; b0 = 32'h3F80_0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      a0 = $urandom; b0 = $urandom;
      #1;
      chk("iso_dp_a", dDpA, 32'h4040_0000);
      chk("iso_dp_b", dDpB, 32'h3F80_0000);
      tick();
    end
    v0 = 1'b0;
    #1;
    chk("iso_result", dRspResult, 32'h4080_0000);
    tick();

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = randFp(); b0 = randFp(); a1 = randFp(); b1 = randFp();
      rspReady = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 120) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
